// File: rtl/linear_tile_scheduler.sv
// Captures one input vector of IN_DEPTH tiles, then replays it OUT_DEPTH times
// with an aligned weight-tile address on every beat.
module linear_tile_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_PAR     = 4,
  parameter int IN_DEPTH   = 4,
  parameter int OUT_DEPTH  = 2,
  parameter int ADDR_WIDTH = (IN_DEPTH * OUT_DEPTH > 1) ? $clog2(IN_DEPTH * OUT_DEPTH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IN_PAR*DATA_WIDTH-1:0] data_in,
  input  logic                         data_in_valid,
  output logic                         data_in_ready,
  output logic [IN_PAR*DATA_WIDTH-1:0] data_out,
  output logic                         data_out_valid,
  input  logic                         data_out_ready,
  output logic [ADDR_WIDTH-1:0]        weight_addr,
  output logic                         last_in,
  output logic                         last_out,
  output logic                         busy
);

  localparam int TILE_W = IN_PAR * DATA_WIDTH;
  localparam int IN_W   = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int OUT_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(IN_DEPTH - 1);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(OUT_DEPTH - 1);

  typedef enum logic {
    LOAD   = 1'b0,
    REPLAY = 1'b1
  } state_t;

  state_t                state_q;
  logic [IN_W-1:0]       wr_idx_q;
  logic [IN_W-1:0]       in_idx_q;
  logic [OUT_W-1:0]      out_idx_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [TILE_W-1:0]     buf_q [IN_DEPTH];

  logic in_hs;
  logic out_hs;
  logic last_in_d;
  logic last_out_d;

  // valid/ready: a transfer happens on a rising edge where both are high;
  // neither ready nor valid depends combinationally on its partner.
  assign data_in_ready  = (state_q == LOAD);
  assign data_out_valid = (state_q == REPLAY);
  assign busy           = (state_q == REPLAY);

  assign in_hs  = data_in_ready & data_in_valid;
  assign out_hs = data_out_valid & data_out_ready;

  assign last_in_d  = (state_q == REPLAY) && (in_idx_q == IN_LAST);
  assign last_out_d = last_in_d && (out_idx_q == OUT_LAST);

  assign last_in     = last_in_d;
  assign last_out    = last_out_d;
  assign data_out    = buf_q[in_idx_q];
  // addr_q tracks out_idx*IN_DEPTH + in_idx incrementally, so no multiplier.
  assign weight_addr = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      wr_idx_q  <= '0;
      in_idx_q  <= '0;
      out_idx_q <= '0;
      addr_q    <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (data_in_valid) begin
            if (wr_idx_q == IN_LAST) begin
              wr_idx_q <= '0;
              state_q  <= REPLAY;
            end else begin
              wr_idx_q <= wr_idx_q + IN_W'(1);
            end
          end
        end
        REPLAY: begin
          if (data_out_ready) begin
            if (last_out_d) begin
              in_idx_q  <= '0;
              out_idx_q <= '0;
              addr_q    <= '0;
              state_q   <= LOAD;
            end else if (in_idx_q == IN_LAST) begin
              in_idx_q  <= '0;
              out_idx_q <= out_idx_q + OUT_W'(1);
              addr_q    <= addr_q + ADDR_WIDTH'(1);
            end else begin
              in_idx_q  <= in_idx_q + IN_W'(1);
              addr_q    <= addr_q + ADDR_WIDTH'(1);
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // Tile storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      buf_q[wr_idx_q] <= data_in;
    end
  end

endmodule

// File: tb/tb_linear_tile_scheduler.sv
// Scoreboard bench for linear_tile_scheduler: a 3x2 instance driven with random
// traffic against a vector-level model, plus a 1x1 degenerate instance.
module tb_linear_tile_scheduler;

  localparam int DW  = 16;
  localparam int PAR = 2;
  localparam int ID  = 3;
  localparam int OD  = 2;
  localparam int AW  = 3;
  localparam int TW  = PAR * DW;
  localparam int EW  = TW + AW + 2;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic          a_rst;
  logic [TW-1:0] a_in;
  logic          a_in_valid;
  logic          a_in_ready;
  logic [TW-1:0] a_out;
  logic          a_out_valid;
  logic          a_out_ready = 1'b1;
  logic [AW-1:0] a_addr;
  logic          a_last_in;
  logic          a_last_out;
  logic          a_busy;

  // degenerate instance
  logic          b_rst;
  logic [TW-1:0] b_in;
  logic          b_in_valid;
  logic          b_in_ready;
  logic [TW-1:0] b_out;
  logic          b_out_valid;
  logic          b_out_ready;
  logic [0:0]    b_addr;
  logic          b_last_in;
  logic          b_last_out;
  logic          b_busy;

  linear_tile_scheduler #(
    .DATA_WIDTH(DW), .IN_PAR(PAR), .IN_DEPTH(ID), .OUT_DEPTH(OD), .ADDR_WIDTH(AW)
  ) dut_a (
    .clk(clk), .rst(a_rst), .data_in(a_in), .data_in_valid(a_in_valid),
    .data_in_ready(a_in_ready), .data_out(a_out), .data_out_valid(a_out_valid),
    .data_out_ready(a_out_ready), .weight_addr(a_addr), .last_in(a_last_in),
    .last_out(a_last_out), .busy(a_busy)
  );

  linear_tile_scheduler #(
    .DATA_WIDTH(DW), .IN_PAR(PAR), .IN_DEPTH(1), .OUT_DEPTH(1), .ADDR_WIDTH(1)
  ) dut_b (
    .clk(clk), .rst(b_rst), .data_in(b_in), .data_in_valid(b_in_valid),
    .data_in_ready(b_in_ready), .data_out(b_out), .data_out_valid(b_out_valid),
    .data_out_ready(b_out_ready), .weight_addr(b_addr), .last_in(b_last_in),
    .last_out(b_last_out), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] mk(input int e0, input int e1);
    logic [DW-1:0] x0;
    logic [DW-1:0] x1;
    x0 = DW'(e0);
    x1 = DW'(e1);
    return {x1, x0};
  endfunction

  // ---------------- reference model + scoreboard ----------------
  bit            m_loading = 1'b1;
  int            m_count = 0;
  logic [TW-1:0] m_tiles [ID];
  logic [EW-1:0] exp_q [$];
  int            beats_seen = 0;
  int            vec_done = 0;
  bit            prev_stall = 1'b0;
  logic [EW-1:0] held;
  logic [EW-1:0] cur;
  logic [EW-1:0] e;

  always @(negedge clk) begin
    cur = {a_out, a_addr, a_last_in, a_last_out};
    if (a_rst) begin
      m_loading  = 1'b1;
      m_count    = 0;
      prev_stall = 1'b0;
      exp_q.delete();
    end else begin
      check("in_ready", a_in_ready, m_loading);
      check("out_valid", a_out_valid, !m_loading);
      check("busy", a_busy, !m_loading);
      if (a_in_valid && m_loading) begin
        m_tiles[m_count] = a_in;
        m_count++;
        if (m_count == ID) begin
          // one full pass over the input tiles per output tile
          for (int o = 0; o < OD; o++)
            for (int i = 0; i < ID; i++)
              exp_q.push_back({m_tiles[i], AW'(o * ID + i), 1'(i == ID - 1),
                               1'((i == ID - 1) && (o == OD - 1))});
          m_loading = 1'b0;
          m_count   = 0;
        end
      end
      if (prev_stall && a_out_valid) check("stall_hold", cur, held);
      prev_stall = 1'b0;
      if (a_out_valid && a_out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(cur), 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("beat", cur, e);
          beats_seen++;
          if (e[0]) begin
            m_loading = 1'b1;
            vec_done++;
          end
        end
      end else if (a_out_valid && !a_out_ready) begin
        prev_stall = 1'b1;
        held       = cur;
      end
    end
  end

  bit rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    a_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic a_load_tile(input logic [TW-1:0] d, input int gap_max);
    int  g;
    int  n;
    logic r;
    g = $urandom_range(0, gap_max);
    n = 0;
    r = 1'b0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    a_in       = d;
    a_in_valid = 1'b1;
    do begin
      @(negedge clk);
      r = a_in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!r && n < 200);
    a_in_valid = 1'b0;
    a_in       = TW'($urandom);
    if (!r) check("load_timeout", 64'(n), 64'h0);
  endtask

  task automatic a_load_random(input int gap_max);
    for (int i = 0; i < ID; i++) a_load_tile(TW'($urandom), gap_max);
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (vec_done < target && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("done_timeout", 64'(vec_done >= target), 64'h1);
  endtask

  initial begin
    int t;
    int n;
    int b0;
    bit fin;
    a_rst = 1'b1; a_in = '0; a_in_valid = 1'b0;
    b_rst = 1'b1; b_in = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    check("rst_addr", a_addr, 0);
    check("rst_last_in", a_last_in, 0);
    check("rst_last_out", a_last_out, 0);
    check("rst_ready", a_in_ready, 1);
    check("rst_valid", a_out_valid, 0);
    @(posedge clk);
    #1;

    // directed vector, always-ready sink
    a_load_tile(mk(1, 2), 0);
    a_load_tile(mk(3, 4), 0);
    a_load_tile(mk(5, 6), 0);
    wait_done(1);

    // random sink backpressure and random load gaps
    rand_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      t = vec_done;
      a_load_random(3);
      wait_done(t + 1);
    end

    // valid kept high with junk tiles throughout replay
    for (int v = 0; v < 3; v++) begin
      t = vec_done;
      a_load_random(2);
      a_in_valid = 1'b1;
      fin = 1'b0;
      n = 0;
      while (!fin && n < 300) begin
        a_in = TW'($urandom);
        @(negedge clk);
        fin = a_out_valid && a_out_ready && a_last_out;
        @(posedge clk);
        #1;
        n++;
      end
      a_in_valid = 1'b0;
      wait_done(t + 1);
    end

    // reset after the third replay beat, then a fresh vector
    rand_ready = 1'b0;
    b0 = beats_seen;
    t  = vec_done;
    a_load_tile(mk(1, 2), 0);
    a_load_tile(mk(3, 4), 0);
    a_load_tile(mk(5, 6), 0);
    n = 0;
    while (beats_seen < b0 + 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    a_rst = 1'b1;
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", a_out_valid, 0);
    check("mid_rst_ready", a_in_ready, 1);
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_vec", 64'(vec_done), 64'(t));
    @(posedge clk);
    #1;
    a_load_tile(mk(7, 8), 1);
    a_load_tile(mk(9, 10), 1);
    a_load_tile(mk(11, 12), 1);
    wait_done(t + 1);

    // two back-to-back vectors with valid held high
    t = vec_done;
    a_in_valid = 1'b1;
    a_in = TW'($urandom);
    n = 0;
    while (vec_done < t + 2 && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      a_in = TW'($urandom);
    end
    a_in_valid = 1'b0;
    check("b2b_cycles", 64'(n), 64'(2 * (ID + ID * OD)));

    // degenerate 1x1 instance
    check("b_rst_ready", b_in_ready, 1);
    check("b_rst_valid", b_out_valid, 0);
    check("b_rst_busy", b_busy, 0);
    b_in = mk(5, 9);
    b_in_valid = 1'b1;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_in = mk(1, 1);
    @(negedge clk);
    check("b_valid", b_out_valid, 1);
    check("b_data", b_out, mk(5, 9));
    check("b_addr", b_addr, 0);
    check("b_last_in", b_last_in, 1);
    check("b_last_out", b_last_out, 1);
    check("b_ready_replay", b_in_ready, 0);
    @(negedge clk);
    check("b_back_valid", b_out_valid, 0);
    check("b_back_ready", b_in_ready, 1);

    repeat (2) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
